// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op and state encodings,
// default width and the stall levels driven toward the pipeline controller.
package div_pkg;

    localparam int DIV_XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    typedef enum logic {
        NoStop = 1'b0,
        Stop   = 1'b1
    } stall_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] diff_s;
    logic          ge_s;

    // The shift drops rem's MSB; when that bit was set the shifted value is
    // already >= 2^XLEN and therefore always exceeds the divisor.
    always_comb begin
        diff_s = {1'b0, rem[XLEN-2:0], quo[XLEN-1]} - {1'b0, divisor};
        ge_s   = rem[XLEN-1] | ~diff_s[XLEN];
        quo_next = {quo[XLEN-2:0], ge_s};
        if (ge_s) begin
            rem_next = diff_s[XLEN-1:0];
        end else begin
            rem_next = {rem[XLEN-2:0], quo[XLEN-1]};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional build macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish at acceptance.
import div_pkg::*;

module div_unit #(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            cancel,
    output logic            ex_stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [XLEN-1:0] rem_r, quo_r, dvs_r, result_r;
    logic            rem_sel_r, neg_quo_r, neg_rem_r, dz_r, ovf_r, valid_r;

    logic            signed_s, sd_s, sv_s, dz_s, ovf_s, accept_s;
    logic [XLEN-1:0] abs_a_s, abs_b_s, spec_val_s;
    logic [XLEN-1:0] rem_nx_s, quo_nx_s, q_fix_s, r_fix_s, fin_s;
    stall_e          stall_lvl_s;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_nx_s),
        .quo_next (quo_nx_s)
    );

    // Operand decode at acceptance: magnitudes, sign flags and special cases.
    always_comb begin
        signed_s = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
        sd_s     = signed_s & dividend[XLEN-1];
        sv_s     = signed_s & divisor[XLEN-1];
        abs_a_s  = sd_s ? -dividend : dividend;
        abs_b_s  = sv_s ? -divisor : divisor;
        dz_s     = (divisor == {XLEN{1'b0}});
        ovf_s    = signed_s && (dividend == MIN_INT) && (divisor == {XLEN{1'b1}});
        accept_s = (state_r == S_IDLE) && start && !cancel;
        if (dz_s) begin
            spec_val_s = op[1] ? dividend : {XLEN{1'b1}};
        end else begin
            spec_val_s = op[1] ? {XLEN{1'b0}} : MIN_INT;
        end
    end

    // Sign correction of the final step, with architectural overrides.
    always_comb begin
        q_fix_s = neg_quo_r ? -quo_nx_s : quo_nx_s;
        r_fix_s = neg_rem_r ? -rem_nx_s : rem_nx_s;
        if (dz_r) begin
            q_fix_s = {XLEN{1'b1}};
        end else if (ovf_r) begin
            q_fix_s = MIN_INT;
            r_fix_s = {XLEN{1'b0}};
        end else begin
            q_fix_s = q_fix_s;
        end
        fin_s = rem_sel_r ? r_fix_s : q_fix_s;
    end

    // Stall request: a divide being accepted this cycle or one in progress.
    always_comb begin
        if (rst && (accept_s || (state_r == S_BUSY))) begin
            stall_lvl_s = Stop;
        end else begin
            stall_lvl_s = NoStop;
        end
    end

    assign ex_stall     = (stall_lvl_s == Stop);
    assign result       = result_r;
    assign result_valid = valid_r & ~cancel;

    // Divider FSM, datapath registers and registered result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= S_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {XLEN{1'b0}};
            quo_r     <= {XLEN{1'b0}};
            dvs_r     <= {XLEN{1'b0}};
            result_r  <= {XLEN{1'b0}};
            rem_sel_r <= 1'b0;
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            ovf_r     <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        rem_sel_r <= op[1];
                        neg_quo_r <= sd_s ^ sv_s;
                        neg_rem_r <= sd_s;
                        dz_r      <= dz_s;
                        ovf_r     <= ovf_s;
                        quo_r     <= abs_a_s;
                        dvs_r     <= abs_b_s;
                        rem_r     <= {XLEN{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
`ifdef DIV_FAST_SPECIAL_EN
                        if (dz_s || ovf_s) begin
                            state_r  <= S_DONE;
                            valid_r  <= 1'b1;
                            result_r <= spec_val_s;
                        end else begin
                            state_r <= S_BUSY;
                        end
`else
                        state_r <= S_BUSY;
`endif
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (cancel) begin
                        state_r <= S_IDLE;
                    end else begin
                        rem_r <= rem_nx_s;
                        quo_r <= quo_nx_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            state_r  <= S_DONE;
                            valid_r  <= 1'b1;
                            result_r <= fin_s;
                        end else begin
                            state_r <= S_BUSY;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
